// File: rtl/vec_pkg.sv
// Shared opcodes, default geometry and FSM state encoding for the vector lane sequencer.
package vec_pkg;

  localparam int VEC_LANES = 5;
  localparam int VEC_DW    = 32;
  localparam int VEC_AW    = 4;

  localparam logic [2:0] OP_VADD = 3'b000;
  localparam logic [2:0] OP_VSUB = 3'b001;
  localparam logic [2:0] OP_VAND = 3'b010;
  localparam logic [2:0] OP_VORR = 3'b011;
  localparam logic [2:0] OP_VMUL = 3'b100;
  localparam logic [2:0] OP_VSUM = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_t;

  function automatic logic op_reserved(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU. Define VEC_SAT_EN to make VADD/VSUB signed-saturating.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int DW = VEC_DW
) (
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y,
  output logic          o_sat
);

  logic [DW-1:0] w_add;
  logic [DW-1:0] w_sub;
  logic          w_add_sat;
  logic          w_sub_sat;

`ifdef VEC_SAT_EN
  localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};

  // Returns {overflow, clamped result}.
  function automatic logic [DW:0] add_sat(input logic signed [DW-1:0] x,
                                          input logic signed [DW-1:0] y);
    logic signed [DW-1:0] s;
    logic                 ovf;
    s   = x + y;
    ovf = (x[DW-1] == y[DW-1]) && (s[DW-1] != x[DW-1]);
    if (ovf) s = x[DW-1] ? MAX_NEG : MAX_POS;
    return {ovf, s};
  endfunction

  function automatic logic [DW:0] sub_sat(input logic signed [DW-1:0] x,
                                          input logic signed [DW-1:0] y);
    logic signed [DW-1:0] d;
    logic                 ovf;
    d   = x - y;
    ovf = (x[DW-1] != y[DW-1]) && (d[DW-1] != x[DW-1]);
    if (ovf) d = x[DW-1] ? MAX_NEG : MAX_POS;
    return {ovf, d};
  endfunction

  assign {w_add_sat, w_add} = add_sat(i_a, i_b);
  assign {w_sub_sat, w_sub} = sub_sat(i_a, i_b);
`else
  assign w_add     = i_a + i_b;
  assign w_sub     = i_a - i_b;
  assign w_add_sat = 1'b0;
  assign w_sub_sat = 1'b0;
`endif

  always_comb begin
    o_y   = '0;
    o_sat = 1'b0;
    case (i_op)
      OP_VADD: begin o_y = w_add; o_sat = w_add_sat; end
      OP_VSUB: begin o_y = w_sub; o_sat = w_sub_sat; end
      OP_VAND: o_y = i_a & i_b;
      OP_VORR: o_y = i_a | i_b;
      OP_VMUL: o_y = i_a * i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Runs one vector instruction lane-serially through a shared ALU, then writes the full vector.
// Build option: VEC_SAT_EN enables saturating VADD/VSUB and the sticky sat report.
module vec_lane_sequencer
  import vec_pkg::*;
#(
  parameter int LANES = VEC_LANES,
  parameter int DW    = VEC_DW,
  parameter int AW    = VEC_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [AW-1:0]       va1,
  input  logic [AW-1:0]       va2,
  input  logic [AW-1:0]       vd,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DW-1:0]       sum,
  output logic                sat,
  output logic [AW-1:0]       vf_va1,
  output logic [AW-1:0]       vf_va2,
  input  logic [LANES*DW-1:0] vr1,
  input  logic [LANES*DW-1:0] vr2,
  output logic                vf_we,
  output logic [AW-1:0]       vf_vd,
  output logic [LANES*DW-1:0] vf_wd
);

  localparam int            LW   = $clog2(LANES);
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LW-1:0]        r_lane;
  logic [2:0]           r_op;
  logic [AW-1:0]        r_va1;
  logic [AW-1:0]        r_va2;
  logic [AW-1:0]        r_vd;
  logic [DW-1:0]        r_sum;
  logic [LANES*DW-1:0]  r_opa_p0;
  logic [LANES*DW-1:0]  r_opb_p0;
  logic [LANES*DW-1:0]  r_res_p1;
  logic [DW-1:0]        w_a;
  logic [DW-1:0]        w_b;
  logic [DW-1:0]        w_y;
  logic                 w_lane_sat;
  logic                 w_accept;

  // The done cycle also accepts, giving back-to-back issue without an idle gap.
  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_WB || r_state == ST_DONE);

  assign w_a = r_opa_p0[DW*r_lane +: DW];
  assign w_b = r_opb_p0[DW*r_lane +: DW];

  vec_lane_alu #(.DW(DW)) u_alu (
    .i_op  (r_op),
    .i_a   (w_a),
    .i_b   (w_b),
    .o_y   (w_y),
    .o_sat (w_lane_sat)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    vf_we       = 1'b0;
    vf_wd       = '0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = op_reserved(r_op) ? ST_DONE : ST_EXEC;
      ST_EXEC: if (r_lane == LAST) w_state_nxt = ST_WB;
      ST_WB: begin
        done        = 1'b1;
        vf_we       = (r_op != OP_VSUM);
        vf_wd       = r_res_p1;
        w_state_nxt = start ? ST_LOAD : ST_IDLE;
      end
      ST_DONE: begin
        done        = 1'b1;
        err         = 1'b1;
        w_state_nxt = start ? ST_LOAD : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_lane  <= '0;
      r_op    <= '0;
      r_va1   <= '0;
      r_va2   <= '0;
      r_vd    <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= op;
        r_va1 <= va1;
        r_va2 <= va2;
        r_vd  <= vd;
        r_sum <= '0;
      end
      if (r_state == ST_EXEC) begin
        r_lane <= (r_lane == LAST) ? '0 : r_lane + 1'b1;
        if (r_op == OP_VSUM) r_sum <= r_sum + w_a;
      end
    end
  end

  // p0: operand capture at end of LOAD; p1: per-lane result collection during EXEC
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_opa_p0 <= vr1;
      r_opb_p0 <= vr2;
    end
    if (r_state == ST_EXEC) r_res_p1[DW*r_lane +: DW] <= w_y;
  end

`ifdef VEC_SAT_EN
  logic r_sat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_sat <= 1'b0;
    else if (w_accept)           r_sat <= 1'b0;
    else if (r_state == ST_EXEC) r_sat <= r_sat | w_lane_sat;
  end
  assign sat = r_sat;
`else
  logic w_unused_sat;
  assign w_unused_sat = w_lane_sat;
  assign sat          = 1'b0;
`endif

  assign sum    = r_sum;
  assign vf_va1 = r_va1;
  assign vf_va2 = r_va2;
  assign vf_vd  = r_vd;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed table-driven bench for vec_lane_sequencer with a behavioural 16-entry register file.
module tb_vec_lane_sequencer;
  import vec_pkg::*;

  localparam int LANES = 5;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int VW    = LANES * DW;
`ifdef VEC_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] va1, va2, vd;
  logic          busy, done, err, sat, vf_we;
  logic [DW-1:0] sum;
  logic [AW-1:0] vf_va1, vf_va2, vf_vd;
  logic [VW-1:0] vr1, vr2, vf_wd;

  logic [VW-1:0] rf [16];
  logic          tb_we;
  logic [3:0]    tb_addr;
  logic [VW-1:0] tb_data;
  logic [VW-1:0] sent;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_lane_sequencer #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .va1(va1), .va2(va2), .vd(vd),
    .busy(busy), .done(done), .err(err), .sum(sum), .sat(sat),
    .vf_va1(vf_va1), .vf_va2(vf_va2), .vr1(vr1), .vr2(vr2),
    .vf_we(vf_we), .vf_vd(vf_vd), .vf_wd(vf_wd)
  );

  assign vr1 = rf[vf_va1];
  assign vr2 = rf[vf_va2];

  always @(posedge clk) begin
    if (vf_we)      rf[vf_vd]   <= vf_wd;
    else if (tb_we) rf[tb_addr] <= tb_data;
  end

  typedef struct {
    logic [2:0]    op;
    logic [3:0]    va1, va2, vd;
    logic [VW-1:0] a, b, exp;
    logic [31:0]   sum;
    logic          err, sat;
    int            cyc;
  } vec_t;

  vec_t tv [11];

  function automatic logic [VW-1:0] v5(input logic [31:0] e0, e1, e2, e3, e4);
    return {e4, e3, e2, e1, e0};
  endfunction

  function automatic vec_t mk(input logic [2:0] o, input logic [3:0] a1, a2, d,
                              input logic [VW-1:0] a, b, exp, input logic [31:0] s,
                              input logic e, st, input int cyc);
    vec_t t;
    t.op = o; t.va1 = a1; t.va2 = a2; t.vd = d;
    t.a = a; t.b = b; t.exp = exp; t.sum = s; t.err = e; t.sat = st; t.cyc = cyc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_reg(input logic [3:0] r, input logic [VW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = r; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [3:0] a1, a2, d,
                        output int dc, output int wc, output logic e, output logic s);
    dc = -1; wc = 0; e = 1'b0; s = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; va1 = a1; va2 = a2; vd = d;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (vf_we) wc++;
      if (done) begin
        dc = c; e = err; s = sat;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    int   dc, wc;
    logic e, s, we_exp;
    load_reg(tv[i].va1, tv[i].a);
    if (tv[i].va2 != tv[i].va1) load_reg(tv[i].va2, tv[i].b);
    if (tv[i].vd != tv[i].va1 && tv[i].vd != tv[i].va2) load_reg(tv[i].vd, sent);
    run_op(tv[i].op, tv[i].va1, tv[i].va2, tv[i].vd, dc, wc, e, s);
    we_exp = !tv[i].err && (tv[i].op != OP_VSUM);
    chk($sformatf("tv%0d.done_cycle", i), dc, tv[i].cyc);
    chk($sformatf("tv%0d.err", i), e, tv[i].err);
    chk($sformatf("tv%0d.sat", i), s, tv[i].sat);
    chk($sformatf("tv%0d.we_pulses", i), wc, we_exp ? 1 : 0);
    if (tv[i].op == OP_VSUM) chk($sformatf("tv%0d.sum", i), sum, tv[i].sum);
    chk($sformatf("tv%0d.vd_data", i), rf[tv[i].vd], we_exp ? tv[i].exp : sent);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            d1, d2, nd, nwe, ndone;
    logic          b8;
    logic [VW-1:0] mid;

    sent = v5(32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004);

    tv[0]  = mk(OP_VADD, 1, 2, 3, v5(1,2,3,4,5), v5(10,20,30,40,50), v5(11,22,33,44,55), 0, 0, 0, 7);
    tv[1]  = mk(OP_VSUM, 1, 2, 5, v5(32'hFFFFFFFF,1,2,3,4), v5(7,7,7,7,7), '0, 32'h9, 0, 0, 7);
    tv[2]  = mk(3'b110, 1, 2, 6, v5(1,2,3,4,5), v5(1,1,1,1,1), '0, 0, 1, 0, 2);
    tv[3]  = mk(OP_VSUB, 5, 6, 7, v5(10,20,30,40,50), v5(1,2,3,4,5), v5(9,18,27,36,45), 0, 0, 0, 7);
    tv[4]  = mk(OP_VAND, 1, 2, 8,
                v5(32'hF0F0F0F0, 32'hFFFFFFFF, 0, 32'h12345678, 32'hAAAAAAAA),
                v5(32'hFF00FF00, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h55555555),
                v5(32'hF000F000, 32'h0000FFFF, 0, 32'h02040608, 0), 0, 0, 0, 7);
    tv[5]  = mk(OP_VORR, 1, 2, 8, tv[4].a, tv[4].b,
                v5(32'hFFF0FFF0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1F3F5F7F, 32'hFFFFFFFF), 0, 0, 0, 7);
    tv[6]  = mk(OP_VMUL, 1, 2, 9,
                v5(32'h00010000, 3, 32'hFFFFFFFF, 32'h00012345, 1000),
                v5(32'h00010000, 7, 2, 32'h100, 1000),
                v5(0, 21, 32'hFFFFFFFE, 32'h01234500, 32'h000F4240), 0, 0, 0, 7);
    tv[7]  = mk(OP_VADD, 1, 2, 10,
                v5(32'h7FFFFFFF, 32'h80000000, 1, 32'h7FFFFFFE, 32'hFFFFFFFF),
                v5(1, 32'hFFFFFFFF, 1, 1, 1),
                SAT_ON ? v5(32'h7FFFFFFF, 32'h80000000, 2, 32'h7FFFFFFF, 0)
                       : v5(32'h80000000, 32'h7FFFFFFF, 2, 32'h7FFFFFFF, 0), 0, 0, SAT_ON, 7);
    tv[8]  = mk(OP_VSUB, 1, 2, 11,
                v5(32'h80000000, 32'h7FFFFFFF, 5, 0, 32'hFFFFFFFF),
                v5(1, 32'hFFFFFFFF, 7, 1, 32'h7FFFFFFF),
                SAT_ON ? v5(32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000)
                       : v5(32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000),
                0, 0, SAT_ON, 7);
    tv[9]  = mk(OP_VADD, 9, 10, 10, v5(100,200,300,400,500), v5(1,1,1,1,1),
                v5(101,201,301,401,501), 0, 0, 0, 7);
    tv[10] = mk(3'b111, 1, 2, 12, v5(1,2,3,4,5), v5(1,2,3,4,5), '0, 0, 1, 0, 2);

    reset = 1'b1; start = 1'b0; op = '0; va1 = '0; va2 = '0; vd = '0;
    tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, err, sat, vf_we, vf_va1, vf_va2, vf_vd, vf_wd, sum}, '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {busy, done, err, sat, vf_we, vf_wd}, '0);

    for (int i = 0; i < 11; i++) apply_vec(i);

    // start held high, VSUB with vd == va1: second op issues from the done cycle
    load_reg(4, v5(5,5,5,5,5));
    load_reg(2, v5(1,2,3,4,5));
    @(negedge clk);
    start = 1'b1; op = OP_VSUB; va1 = 4; va2 = 2; vd = 4;
    nd = 0; d1 = -1; d2 = -1; b8 = 1'b0; mid = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      if (c == 8) begin mid = rf[4]; b8 = busy; end
    end
    start = 1'b0;
    @(negedge clk);
    chk("b2b.first_done", d1, 7);
    chk("b2b.second_done", d2, 14);
    chk("b2b.done_count", nd, 2);
    chk("b2b.v4_after_first", mid, v5(4,3,2,1,0));
    chk("b2b.busy_cycle8", b8, 1'b1);
    chk("b2b.v4_final", rf[4], v5(3,1,32'hFFFFFFFF,32'hFFFFFFFD,32'hFFFFFFFB));
    chk("b2b.idle_after", busy, 1'b0);

    // reset during EXEC lane 2
    load_reg(1, v5(1,2,3,4,5));
    load_reg(2, v5(10,20,30,40,50));
    load_reg(3, sent);
    @(negedge clk);
    start = 1'b1; op = OP_VADD; va1 = 1; va2 = 2; vd = 3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid.busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_mid.outputs", {busy, done, err, sat, vf_we, vf_va1, vf_va2, vf_vd, vf_wd, sum}, '0);
    @(negedge clk);
    reset = 1'b0;
    nwe = 0; ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (vf_we) nwe++;
      if (done) ndone++;
    end
    chk("rst_mid.no_write", nwe, 0);
    chk("rst_mid.no_done", ndone, 0);
    chk("rst_mid.v3_unchanged", rf[3], sent);

    apply_vec(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
